// File: rtl/kc87_pkg.sv
// Shared state encoding and TAP file constants for the KC87 tape loader.
package kc87_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SIG,
        HBN,
        HDR,
        DBN,
        DATA,
        WREQ,
        WRITE,
        DONE,
        ERR
    } tap_state_t;

    localparam logic [7:0]  TAP_SIG_BYTE0 = 8'hC3;

    // File offsets of the little-endian header words (low byte first).
    localparam logic [7:0]  HDR_AADR      = 8'd17;
    localparam logic [7:0]  HDR_EADR      = 8'd19;
    localparam logic [7:0]  HDR_SADR      = 8'd21;

    localparam logic [15:0] NO_AUTOSTART  = 16'hFFFF;

endpackage

// File: rtl/kc87_tap_hdr_parse.sv
// Latches the load-start, load-end and autostart words of a TAP header,
// selected by the file offset of each incoming header byte.
module kc87_tap_hdr_parse
    import kc87_pkg::*;
(
    input  logic        clk,
    input  logic        hdr_we,
    input  logic [7:0]  hdr_off,
    input  logic [7:0]  hdr_byte,
    output logic [15:0] aadr,
    output logic [15:0] eadr,
    output logic [15:0] sadr
);

    localparam logic [7:0] AADR_HI = HDR_AADR + 8'd1;
    localparam logic [7:0] EADR_HI = HDR_EADR + 8'd1;
    localparam logic [7:0] SADR_HI = HDR_SADR + 8'd1;

    // Header words are always rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (hdr_we) begin
            case (hdr_off)
                HDR_AADR: aadr[7:0]  <= hdr_byte;
                AADR_HI:  aadr[15:8] <= hdr_byte;
                HDR_EADR: eadr[7:0]  <= hdr_byte;
                EADR_HI:  eadr[15:8] <= hdr_byte;
                HDR_SADR: sadr[7:0]  <= hdr_byte;
                SADR_HI:  sadr[15:8] <= hdr_byte;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/kc87_tap_loader.sv
// Streams a KC87 TAP file from the hps_io download port into main RAM.
// Build option KC87_TAP_AUTOSTART_EN enables the start_valid/start_addr autostart pulse.
module kc87_tap_loader
    import kc87_pkg::*;
#(
    parameter logic [7:0] TAP_INDEX = 8'd1,
    parameter int         SIG_LEN   = 16,
    parameter int         BLK_LEN   = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] start_addr,
    output logic        start_valid
);

    tap_state_t  state;
    logic        act_q;
    logic [7:0]  byte_cnt;
    logic [7:0]  blk_cnt;
    logic [15:0] waddr;
    logic [7:0]  wbyte;
    logic        blk_end_q;
    logic        eof_pend;
    logic        overrun;
    logic [15:0] aadr;
    logic [15:0] eadr;
    logic [15:0] sadr;

    logic        active;
    logic        act_rise;
    logic        act_fall;
    logic        strobe;
    logic        blk_last;
    logic        in_range;
    logic        hdr_we;

    assign active   = ioctl_download && (ioctl_index == TAP_INDEX);
    assign act_rise = active && !act_q;
    assign act_fall = !active && act_q;
    assign strobe   = ioctl_wr && active;
    assign blk_last = (blk_cnt == 8'(BLK_LEN - 1));
    assign in_range = !overrun && (waddr <= eadr);
    assign hdr_we   = (state == HDR) && strobe;

    kc87_tap_hdr_parse u_hdr_parse (
        .clk      (clk),
        .hdr_we   (hdr_we),
        .hdr_off  (byte_cnt),
        .hdr_byte (ioctl_data),
        .aadr     (aadr),
        .eadr     (eadr),
        .sadr     (sadr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            act_q      <= 1'b0;
            byte_cnt   <= '0;
            blk_cnt    <= '0;
            waddr      <= '0;
            blk_end_q  <= 1'b0;
            eof_pend   <= 1'b0;
            overrun    <= 1'b0;
            ioctl_wait <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_dout   <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef KC87_TAP_AUTOSTART_EN
            start_addr  <= '0;
            start_valid <= 1'b0;
`endif
        end else begin
            act_q     <= active;
            load_done <= 1'b0;
`ifdef KC87_TAP_AUTOSTART_EN
            start_valid <= 1'b0;
`endif
            case (state)
                // hps_io raises ioctl_download at least one cycle before the first strobe.
                IDLE: begin
                    if (act_rise) begin
                        load_err <= 1'b0;
                        cpu_hold <= 1'b1;
                        byte_cnt <= '0;
                        overrun  <= 1'b0;
                        eof_pend <= 1'b0;
                        state    <= SIG;
                    end
                end
                SIG: begin
                    if (act_fall) begin
                        state <= ERR;
                    end else if (strobe) begin
                        byte_cnt <= byte_cnt + 8'd1;
                        if (byte_cnt == '0 && ioctl_data != TAP_SIG_BYTE0)
                            state <= ERR;
                        else if (byte_cnt == 8'(SIG_LEN - 1))
                            state <= HBN;
                    end
                end
                HBN: begin
                    if (act_fall) begin
                        state <= ERR;
                    end else if (strobe) begin
                        byte_cnt <= byte_cnt + 8'd1;
                        blk_cnt  <= '0;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (act_fall) begin
                        state <= ERR;
                    end else if (strobe) begin
                        byte_cnt <= byte_cnt + 8'd1;
                        blk_cnt  <= blk_cnt + 8'd1;
                        if (blk_last) begin
                            if (eadr < aadr) begin
                                state <= ERR;
                            end else begin
                                waddr <= aadr;
                                state <= DBN;
                            end
                        end
                    end
                end
                DBN: begin
                    if (act_fall) begin
                        if (in_range)
                            load_err <= 1'b1;
                        state <= DONE;
                    end else if (strobe) begin
                        blk_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (act_fall) begin
                        if (in_range)
                            load_err <= 1'b1;
                        state <= DONE;
                    end else if (strobe) begin
                        blk_cnt <= blk_cnt + 8'd1;
                        if (in_range) begin
                            wbyte      <= ioctl_data;
                            blk_end_q  <= blk_last;
                            ioctl_wait <= 1'b1;
                            mem_req    <= 1'b1;
                            state      <= WREQ;
                        end else if (blk_last) begin
                            state <= DBN;
                        end
                    end
                end
                WREQ: begin
                    if (strobe) begin
                        mem_req    <= 1'b0;
                        ioctl_wait <= 1'b0;
                        state      <= ERR;
                    end else begin
                        if (act_fall)
                            eof_pend <= 1'b1;
                        if (mem_gnt) begin
                            mem_we   <= 1'b1;
                            mem_addr <= waddr;
                            mem_dout <= wbyte;
                            state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    mem_we     <= 1'b0;
                    mem_req    <= 1'b0;
                    ioctl_wait <= 1'b0;
                    if (strobe) begin
                        state <= ERR;
                    end else begin
                        waddr <= waddr + 16'd1;
                        if (waddr == 16'hFFFF)
                            overrun <= 1'b1;
                        // A download that ended during the write is judged on the post-write address.
                        if (eof_pend || act_fall) begin
                            if (waddr != eadr && waddr != 16'hFFFF)
                                load_err <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= blk_end_q ? DBN : DATA;
                        end
                    end
                end
                DONE: begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
`ifdef KC87_TAP_AUTOSTART_EN
                    if (sadr != NO_AUTOSTART) begin
                        start_addr  <= sadr;
                        start_valid <= 1'b1;
                    end
`endif
                    state <= IDLE;
                end
                ERR: begin
                    load_err <= 1'b1;
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KC87_TAP_AUTOSTART_EN
    logic unused_inputs;
    assign unused_inputs = ^ioctl_addr;
`else
    logic unused_inputs;
    assign unused_inputs = ^{ioctl_addr, sadr};
    assign start_addr    = 16'h0000;
    assign start_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_kc87_tap_loader.sv
// Scoreboard bench for kc87_tap_loader: expected RAM writes are queued as file bytes are sent.
module tb_kc87_tap_loader;
    import kc87_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] start_addr;
    logic        start_valid;

    always #5 clk_sys = ~clk_sys;

    kc87_tap_loader #(.TAP_INDEX(8'd1), .SIG_LEN(16), .BLK_LEN(128)) dut (
        .clk            (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_gnt        (mem_gnt),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .cpu_hold       (cpu_hold),
        .load_done      (load_done),
        .load_err       (load_err),
        .start_addr     (start_addr),
        .start_valid    (start_valid)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] sb_q[$];
    logic [23:0] sb_exp;
    int          n_we;
    int          n_done;
    int          gnt_delay;
    int          gnt_cnt;
    bit          exp_sv;
    logic [15:0] exp_saddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Arbiter model: grant immediately, or after gnt_delay cycles of request.
    initial begin
        mem_gnt = 1'b0;
        gnt_cnt = 0;
        forever begin
            @(posedge clk_sys); #1;
            if (gnt_delay == 0) begin
                mem_gnt = 1'b1;
            end else if (mem_req) begin
                if (gnt_cnt >= gnt_delay) mem_gnt = 1'b1;
                else gnt_cnt++;
            end else begin
                mem_gnt = 1'b0;
                gnt_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (mem_req) check("stall_wait", 32'(ioctl_wait), 32'd1);
            if (mem_we) begin
                n_we++;
                check("we_gnt", 32'(mem_gnt), 32'd1);
                if (sb_q.size() > 0) begin
                    sb_exp = sb_q.pop_front();
                    check("we_addr", 32'(mem_addr), 32'(sb_exp[23:8]));
                    check("we_data", 32'(mem_dout), 32'(sb_exp[7:0]));
                end
            end
            if (load_done) n_done++;
            if (load_done || start_valid) begin
                check("sv_done", 32'(start_valid), 32'(load_done && exp_sv));
                if (start_valid) check("sv_addr", 32'(start_addr), 32'(exp_saddr));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (ioctl_wait && n < 200) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (n >= 200) check("wait_tmo", 32'(ioctl_wait), 32'd0);
        ioctl_data = b;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b0;
        ioctl_addr = ioctl_addr + 25'd1;
        @(posedge clk_sys); #1;
    endtask

    task automatic send_file(input logic [15:0] aadr, input logic [15:0] eadr,
                             input logic [15:0] sadr, input int ndata);
        logic [7:0] b;
        bit         hdr_ok;
        hdr_ok = (eadr >= aadr);
        for (int i = 0; i < 16; i++) send_byte(i == 0 ? TAP_SIG_BYTE0 : 8'(8'h40 + i));
        send_byte(8'h00);
        for (int j = 0; j < 128; j++) begin
            b = 8'h00;
            case (j)
                0: b = aadr[7:0];
                1: b = aadr[15:8];
                2: b = eadr[7:0];
                3: b = eadr[15:8];
                4: b = sadr[7:0];
                5: b = sadr[15:8];
                default: b = 8'h00;
            endcase
            send_byte(b);
        end
        for (int k = 0; k < ndata; k++) begin
            if (k % 128 == 0) send_byte(8'(k / 128 + 1));
            b = 8'($urandom_range(0, 255));
            if (hdr_ok && (32'(aadr) + k <= 32'(eadr))) sb_q.push_back({16'(32'(aadr) + k), b});
            send_byte(b);
        end
    endtask

    task automatic start_dl(input logic [7:0] idx);
        n_we   = 0;
        n_done = 0;
        sb_q.delete();
        ioctl_index    = idx;
        ioctl_addr     = '0;
        ioctl_download = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic end_dl();
        int n;
        n = 0;
        ioctl_download = 1'b0;
        while (cpu_hold && n < 50) begin
            @(posedge clk_sys); #1;
            n++;
        end
        repeat (3) @(posedge clk_sys);
        #1;
        check("hold_end", 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = 8'd0;
        gnt_delay      = 0;
        exp_sv         = 1'b0;
        exp_saddr      = 16'h0000;
        n_we           = 0;
        n_done         = 0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_req",  32'(mem_req),    32'd0);
        check("rst_we",   32'(mem_we),     32'd0);
        check("rst_hold", 32'(cpu_hold),   32'd0);
        check("rst_err",  32'(load_err),   32'd0);
        check("rst_done", 32'(load_done),  32'd0);
        check("rst_sv",   32'(start_valid), 32'd0);
        check("rst_sa",   32'(start_addr), 32'd0);
        reset = 1'b0;
        @(posedge clk_sys); #1;

        // Download for another index is ignored.
        start_dl(8'd2);
        send_byte(TAP_SIG_BYTE0);
        send_byte(8'h55);
        check("idx_hold", 32'(cpu_hold),   32'd0);
        check("idx_wait", 32'(ioctl_wait), 32'd0);
        end_dl();
        check("idx_nwe",  32'(n_we),     32'd0);
        check("idx_err",  32'(load_err), 32'd0);

        // Normal two-block load, second block beyond eadr.
`ifdef KC87_TAP_AUTOSTART_EN
        exp_sv = 1'b1;
`endif
        exp_saddr = 16'h0300;
        start_dl(8'd1);
        check("t1_hold", 32'(cpu_hold), 32'd1);
        send_file(16'h0300, 16'h037F, 16'h0300, 256);
        end_dl();
        check("t1_nwe",  32'(n_we),        32'd128);
        check("t1_sb",   32'(sb_q.size()), 32'd0);
        check("t1_done", 32'(n_done),      32'd1);
        check("t1_err",  32'(load_err),    32'd0);
`ifdef KC87_TAP_AUTOSTART_EN
        check("t1_sa",   32'(start_addr),  32'h0300);
`else
        check("t1_sa",   32'(start_addr),  32'h0000);
`endif

        // Same file with a slow arbiter and no autostart.
        exp_sv    = 1'b0;
        gnt_delay = 5;
        start_dl(8'd1);
        send_file(16'h0300, 16'h037F, 16'hFFFF, 256);
        end_dl();
        check("t2_nwe",  32'(n_we),        32'd128);
        check("t2_sb",   32'(sb_q.size()), 32'd0);
        check("t2_done", 32'(n_done),      32'd1);
        check("t2_err",  32'(load_err),    32'd0);
        gnt_delay = 0;

        // Bad signature byte 0.
        start_dl(8'd1);
        check("t3_hold_on", 32'(cpu_hold), 32'd1);
        send_byte(8'h00);
        check("t3_hold", 32'(cpu_hold), 32'd0);
        check("t3_err",  32'(load_err), 32'd1);
        send_byte(TAP_SIG_BYTE0);
        send_byte(8'h41);
        end_dl();
        check("t3_nwe",  32'(n_we),   32'd0);
        check("t3_done", 32'(n_done), 32'd0);

        // eadr below aadr is rejected at the end of the header.
        start_dl(8'd1);
        check("t4_errclr", 32'(load_err), 32'd0);
        send_file(16'h0400, 16'h0350, 16'hFFFF, 0);
        check("t4_err",  32'(load_err), 32'd1);
        check("t4_hold", 32'(cpu_hold), 32'd0);
        send_byte(8'h01);
        send_byte(8'hAA);
        end_dl();
        check("t4_nwe",  32'(n_we),   32'd0);
        check("t4_done", 32'(n_done), 32'd0);

        // Download ends after 40 data bytes.
        start_dl(8'd1);
        send_file(16'h0300, 16'h037F, 16'hFFFF, 40);
        end_dl();
        check("t5_nwe",  32'(n_we),        32'd40);
        check("t5_sb",   32'(sb_q.size()), 32'd0);
        check("t5_done", 32'(n_done),      32'd1);
        check("t5_err",  32'(load_err),    32'd1);

        // Reset while a write request is pending.
        gnt_delay = 5;
        start_dl(8'd1);
        send_file(16'h0300, 16'h037F, 16'hFFFF, 1);
        check("t6_req_pre",  32'(mem_req),    32'd1);
        check("t6_wait_pre", 32'(ioctl_wait), 32'd1);
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk_sys); #1;
        check("t6_req",  32'(mem_req),    32'd0);
        check("t6_wait", 32'(ioctl_wait), 32'd0);
        check("t6_hold", 32'(cpu_hold),   32'd0);
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk_sys);
        #1;
        check("t6_nwe",  32'(n_we),   32'd0);
        check("t6_done", 32'(n_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/kc87_tap_loader.md
Name: kc87_tap_loader

Overview:
- Sequences a KC87 TAP file from the HPS ioctl download stream into the shared 64 KiB main RAM.
- Parses the 16-byte signature, the header block and the data blocks, then arbitrates with the Z80 for RAM write slots.
- Throttles the HPS stream through ioctl_wait.
- Sits inside the kc87 core between the hps_io download port and the RAM arbiter.

Parameters:
- TAP_INDEX, 8'd1, ioctl_index value that selects this loader; downloads with any other index are ignored.
- SIG_LEN, 16, signature bytes skipped at file start.
- BLK_LEN, 128, payload bytes per block. Each block occupies 1 + BLK_LEN file bytes.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download selector.
- ioctl_wr  in  1  byte strobe, one cycle.
- ioctl_addr  in  25  file offset of the byte (informational; the byte counter is authoritative).
- ioctl_data  in  8  file byte.
- ioctl_wait  out  1  stall request to hps_io.
- mem_req  out  1  RAM slot request to the arbiter.
- mem_gnt  in  1  RAM slot granted; held while mem_req is high.
- mem_we  out  1  write strobe, one cycle, only while mem_gnt=1.
- mem_addr  out  16  RAM write address.
- mem_dout  out  8  RAM write data.
- cpu_hold  out  1  high from first signature byte until DONE/ERR; keeps CPU in wait.
- load_done  out  1  one-cycle pulse when the file is fully consumed.
- load_err  out  1  sticky error flag; cleared by reset or the next download start.
- start_addr  out  16  autostart address from the header.
- start_valid  out  1  see Optional Feature.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters 0.
- Every output is registered.
- Active download means ioctl_download=1 and ioctl_index=TAP_INDEX.
- FSM states: IDLE, SIG, HBN, HDR, DBN, DATA, WREQ, WRITE, DONE, ERR.
- IDLE -> SIG on the rising edge of an active download. This clears load_err, sets cpu_hold and zeroes the byte counter.
- SIG: count SIG_LEN bytes. If byte 0 is not 8'hC3 -> ERR. When the count reaches SIG_LEN -> HBN.
- HBN: consume the block-number byte -> HDR.
- HDR: consume BLK_LEN bytes and latch fields, all little-endian:
  - bytes 17..18 = aadr (load start).
  - bytes 19..20 = eadr (load end, inclusive).
  - bytes 21..22 = sadr (autostart).
  - At byte BLK_LEN-1: if eadr < aadr -> ERR, else waddr <= aadr -> DBN.
- DBN: consume the block-number byte -> DATA.
- DATA, on each ioctl_wr:
  - If waddr <= eadr and no overrun has occurred: latch the byte, set ioctl_wait in the same clock edge -> WREQ.
  - Otherwise discard the byte.
  - After the BLK_LEN-th byte of the block -> DBN.
- WREQ: mem_req=1. When mem_gnt=1 -> WRITE.
- WRITE:
  - mem_we=1 for exactly one cycle with mem_addr=waddr and mem_dout=the latched byte.
  - Then clear mem_req and ioctl_wait, increment waddr -> DATA, or -> DBN if the block ended.
  - Latency from ioctl_wr to mem_we is 2 cycles plus grant wait.
- Address wrap: if waddr=16'hFFFF is written, set an overrun flag; all further bytes are discarded (no wrap to 0).
- ioctl_download falling edge:
  - If in DBN/DATA/HBN/HDR/SIG:
    - in DBN or DATA with waddr > eadr -> DONE;
    - in HBN, HDR or SIG -> ERR;
    - in DBN or DATA with waddr <= eadr (short file) -> DONE with load_err=1.
  - If in WREQ/WRITE: finish the pending write first, then evaluate as above.
- DONE: pulse load_done, drop cpu_hold -> IDLE.
- ERR: set load_err, drop cpu_hold -> IDLE.
- ioctl_wr is never accepted while ioctl_wait=1; a strobe arriving in WREQ/WRITE is a protocol violation -> ERR.
- Inactive index: loader stays IDLE and all outputs stay 0.
- Reset mid-load: immediate return to IDLE; mem_req, mem_we and ioctl_wait drop in the same cycle.

Optional Feature:
- Macro: KC87_TAP_AUTOSTART_EN.
- Defined: in DONE, if sadr != 16'hFFFF, start_addr <= sadr and start_valid pulses one cycle together with load_done. The CPU wrapper uses this pulse to force a jump.
- Undefined: start_valid is tied to 0 and start_addr to 16'h0000; the header autostart field is parsed but unused.

Decomposition:
- Package kc87_pkg holds:
  - the tap_state_t enum;
  - TAP_SIG_BYTE0 = 8'hC3;
  - header offsets HDR_AADR = 17, HDR_EADR = 19, HDR_SADR = 21;
  - NO_AUTOSTART = 16'hFFFF.
- One sub-module, kc87_tap_hdr_parse: byte-offset-addressed latch of aadr/eadr/sadr. Keeps the main FSM focused on sequencing and arbitration.

Test Plan:
- Normal load, aadr=0x0300, eadr=0x037F, 2 data blocks, mem_gnt always 1 -> exactly 128 mem_we at addresses 0x0300..0x037F, block 2 bytes discarded, load_done pulses once, load_err=0.
- Same file with mem_gnt delayed 5 cycles per request -> ioctl_wait stays high through each stall, no byte lost, mem_we only while mem_gnt=1.
- Signature byte 0 = 0x00 -> load_err=1, zero mem_we, cpu_hold low within 2 cycles.
- eadr=0x0350 < aadr=0x0400 -> ERR at the end of the header, no writes.
- Download ends after 40 data bytes with eadr=0x037F -> DONE with load_err=1, 40 writes performed.
- With KC87_TAP_AUTOSTART_EN and sadr=0x0300 -> start_valid and load_done coincide, start_addr=0x0300; with sadr=0xFFFF -> start_valid stays 0. Reset asserted mid-WREQ -> mem_req=0 and ioctl_wait=0 next cycle.
